// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder serving one transaction at a time from a single-port word SRAM.
// Define AXI_SLV_BURST_EN for multi-beat INCR bursts; without it only single-beat transfers are served.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t            state, state_nxt;
    logic              last_wr;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              grant_rd, grant_wr;
    logic              rd_last, wr_last, rd_err, mem_ok, err_beat;

`ifdef AXI_SLV_BURST_EN
    logic [7:0] len_q, cnt_q;
    assign rd_last  = (cnt_q == len_q);
    assign wr_last  = (cnt_q == len_q);
    assign rd_err   = 1'b0;
    assign mem_ok   = 1'b1;
    assign err_beat = wlast ^ wr_last;
`else
    // Multi-beat requests are answered with an error and never touch the SRAM.
    logic long_q;
    assign rd_last  = 1'b1;
    assign wr_last  = long_q ? wlast : 1'b1;
    assign rd_err   = long_q;
    assign mem_ok   = ~long_q;
    assign err_beat = long_q | ~wlast;
`endif

    logic unused_ok;
    assign unused_ok = ^{arsize, arburst, awsize, awburst, wid,
                         araddr[31:ADDR_W+2], awaddr[31:ADDR_W+2]};

    // Tie goes to whichever channel was not granted last time.
    assign grant_rd = arvalid && (!awvalid || last_wr);
    assign grant_wr = awvalid && !grant_rd;

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        rvalid    = 1'b0;
        bvalid    = 1'b0;
        ram_en    = 1'b0;
        ram_wen   = 4'b0000;
        ram_addr  = addr_q;
        ram_wdata = wdata;
        case (state)
            IDLE: begin
                arready = grant_rd && !areset;
                awready = grant_wr && !areset;
                if (grant_rd)      state_nxt = RD_REQ;
                else if (grant_wr) state_nxt = WR_DATA;
            end
            RD_REQ: begin
                ram_en    = ~rd_err;
                state_nxt = RD_CAP;
            end
            RD_CAP: state_nxt = RD_RESP;
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) state_nxt = rd_last ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_en  = mem_ok;
                    ram_wen = mem_ok ? wstrb : 4'b0000;
                    if (wr_last) state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            last_wr <= 1'b1;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
            rid     <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
`ifdef AXI_SLV_BURST_EN
            len_q   <= '0;
            cnt_q   <= '0;
`else
            long_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arready) begin
                        last_wr <= 1'b0;
                        rid     <= arid;
                        addr_q  <= araddr[ADDR_W+1:2];
`ifdef AXI_SLV_BURST_EN
                        len_q   <= arlen;
                        cnt_q   <= '0;
`else
                        long_q  <= (arlen != 8'd0);
`endif
                    end else if (awready) begin
                        last_wr <= 1'b1;
                        bid     <= awid;
                        addr_q  <= awaddr[ADDR_W+1:2];
                        err_q   <= 1'b0;
`ifdef AXI_SLV_BURST_EN
                        len_q   <= awlen;
                        cnt_q   <= '0;
`else
                        long_q  <= (awlen != 8'd0);
`endif
                    end
                end
                RD_CAP: begin
                    rdata <= rd_err ? 32'h0 : ram_rdata;
                    rlast <= rd_last;
                    rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
                end
                RD_RESP: begin
                    if (rready && !rd_last) begin
                        addr_q <= addr_q + ADDR_W'(1);
`ifdef AXI_SLV_BURST_EN
                        cnt_q  <= cnt_q + 8'd1;
`endif
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        err_q <= err_q | err_beat;
                        if (wr_last) begin
                            bresp <= (err_q || err_beat) ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
`ifdef AXI_SLV_BURST_EN
                            cnt_q  <= cnt_q + 8'd1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave against a transaction-level memory model.
module tb_axi_sram_slave;
    logic        aclk, areset;
    logic [3:0]  arid, rid, awid, wid, bid, wstrb, ram_wen;
    logic [31:0] araddr, awaddr, rdata, wdata, ram_wdata, ram_rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, ram_en;
    logic [15:0] ram_addr;

    logic [31:0] sram    [0:65535];
    logic [31:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;
    int g;
    int r_len, r_wl;
    logic [31:0] r_addr;

    axi_sram_slave #(.ADDR_W(16)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Synchronous SRAM seen by the DUT: read data appears the cycle after the strobe.
    always @(posedge aclk) begin
        if (ram_en) begin
            if (ram_wen == 4'b0000) ram_rdata <= sram[ram_addr];
            else for (int k = 0; k < 4; k++)
                if (ram_wen[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input int mode);
        int nbeats, beat, lat, guard, en_cnt, exp_en;
        logic [15:0] wa;
        logic [1:0]  exp_resp;
        bit seen;
        wa = addr[17:2];
`ifdef AXI_SLV_BURST_EN
        nbeats = int'(len) + 1; exp_resp = 2'b00; exp_en = nbeats;
`else
        nbeats = 1; exp_resp = (len != 8'd0) ? 2'b10 : 2'b00; exp_en = (len != 8'd0) ? 0 : 1;
`endif
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        #1;
        guard = 0;
        while (!arready && guard < 64) begin @(negedge aclk); #1; guard++; end
        check("ar_ready", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        beat = 0; lat = 1; seen = 0; en_cnt = 0; guard = 0; rready = 1'b0;
        while (beat < nbeats && guard < 300) begin
            if (ram_en) en_cnt++;
            case (mode)
                0:       rready = 1'($urandom_range(0, 1));
                1:       rready = ~rready;
                default: rready = 1'b1;
            endcase
            if (rvalid) begin
                if (!seen) begin check("rd_latency", 32'(lat), 32'd3); seen = 1; end
                if (exp_resp == 2'b00)
                    check("rd_data", rdata, ref_mem[16'(wa + 16'(beat))]);
                check("rd_id", 32'(rid), 32'(id));
                check("rd_resp", 32'(rresp), 32'(exp_resp));
                check("rd_last", 32'(rlast), 32'(beat == nbeats - 1));
                if (rready) begin beat++; lat = 0; seen = 0; end
            end
            @(negedge aclk);
            lat++; guard++;
        end
        if (beat < nbeats) check("rd_timeout", 32'd0, 32'd1);
        check("rd_idle", 32'(rvalid), 32'd0);
        check("rd_ram_strobes", 32'(en_cnt), 32'(exp_en));
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int wlast_at, input logic [31:0] d0, input logic [3:0] s0,
                            input bit gaps);
        int nbeats, beat, guard;
        logic [15:0] wa;
        logic [1:0]  exp_resp;
        logic [31:0] d;
        logic [3:0]  s;
        bit do_mem, done;
        wa = addr[17:2];
`ifdef AXI_SLV_BURST_EN
        nbeats = int'(len) + 1; do_mem = 1;
        exp_resp = (wlast_at != int'(len)) ? 2'b10 : 2'b00;
`else
        if (len == 8'd0) begin
            nbeats = 1; do_mem = 1; exp_resp = (wlast_at != 0) ? 2'b10 : 2'b00;
        end else begin
            nbeats = wlast_at + 1; do_mem = 0; exp_resp = 2'b10;
        end
`endif
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        #1;
        guard = 0;
        while (!awready && guard < 64) begin @(negedge aclk); #1; guard++; end
        check("aw_ready", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        check("w_ready_first", 32'(wready), 32'd1);
        beat = 0; guard = 0;
        while (beat < nbeats && guard < 300) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0; #1;
                check("w_gap_ram_en", 32'(ram_en), 32'd0);
            end else begin
                d = (beat == 0) ? d0 : $urandom;
                s = (beat == 0) ? s0 : 4'($urandom);
                wid = 4'($urandom); wdata = d; wstrb = s;
                wlast = (beat == wlast_at); wvalid = 1'b1;
                #1;
                check("w_ready", 32'(wready), 32'd1);
                check("w_ram_en", 32'(ram_en), 32'(do_mem));
                if (do_mem) begin
                    check("w_ram_wen", 32'(ram_wen), 32'(s));
                    check("w_ram_addr", 32'(ram_addr), 32'(16'(wa + 16'(beat))));
                    check("w_ram_wdata", ram_wdata, d);
                    for (int k = 0; k < 4; k++)
                        if (s[k]) ref_mem[16'(wa + 16'(beat))][8*k +: 8] = d[8*k +: 8];
                end
                beat++;
            end
            @(negedge aclk);
            guard++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("b_valid_next", 32'(bvalid), 32'd1);
        done = 0; guard = 0;
        while (!done && guard < 64) begin
            bready = 1'($urandom_range(0, 1));
            check("b_valid", 32'(bvalid), 32'd1);
            check("b_id", 32'(bid), 32'(id));
            check("b_resp", 32'(bresp), 32'(exp_resp));
            if (bready) done = 1;
            @(negedge aclk);
            guard++;
        end
        bready = 1'b0;
        check("b_idle", 32'(bvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A_0F0F;
            ref_mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A_0F0F;
        end
        sram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        arvalid = 1'b1; awvalid = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);

        // Both channels held high from reset: grants must alternate read, write, read, write.
        areset = 1'b0; #1;
        check("arb0_ar", 32'(arready), 32'd1);
        check("arb0_aw", 32'(awready), 32'd0);
        do_read(4'd3, 32'h0000_0010, 8'd0, 2);
        arvalid = 1'b1; #1;
        check("arb1_aw", 32'(awready), 32'd1);
        check("arb1_ar", 32'(arready), 32'd0);
        do_write(4'd6, 32'h0000_0008, 8'd0, 0, 32'h1122_3344, 4'b0101, 0);
        awvalid = 1'b1; #1;
        check("arb2_ar", 32'(arready), 32'd1);
        check("arb2_aw", 32'(awready), 32'd0);
        do_read(4'd6, 32'h0000_0008, 8'd0, 0);
        arvalid = 1'b1; #1;
        check("arb3_aw", 32'(awready), 32'd1);
        check("arb3_ar", 32'(arready), 32'd0);
        do_write(4'd9, 32'h0000_0040, 8'd0, 0, $urandom, 4'hF, 1);
        arvalid = 1'b0;

        // Four-beat burst, then read back with rready toggling every cycle.
        do_write(4'd2, 32'h0000_0100, 8'd3, 3, $urandom, 4'hF, 1);
        do_read(4'd4, 32'h0000_0100, 8'd3, 1);

        // Early wlast on a two-beat burst.
        do_write(4'd7, 32'h0000_0200, 8'd1, 0, $urandom, 4'hF, 0);
        do_read(4'd7, 32'h0000_0200, 8'd1, 2);

        // Reset while a read response is pending.
        @(negedge aclk);
        arid = 4'd5; araddr = 32'h0000_0020; arlen = 8'd0; arvalid = 1'b1; #1;
        g = 0;
        while (!arready && g < 64) begin @(negedge aclk); #1; g++; end
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b0;
        g = 0;
        while (!rvalid && g < 8) begin @(negedge aclk); g++; end
        check("rst_mid_rvalid_pre", 32'(rvalid), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rlast", 32'(rlast), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_rid", 32'(rid), 32'd0);
        check("rst_mid_ram_en", 32'(ram_en), 32'd0);
        areset = 1'b0;
        do_read(4'd5, 32'h0000_0020, 8'd0, 0);

        // Random traffic, including bursts that wrap the top of the word space.
        for (int it = 0; it < 40; it++) begin
            r_addr = {14'($urandom), 16'(($urandom_range(0, 1) != 0 ? 16'hFFF0 : 16'h0000)
                      + 16'($urandom_range(0, 63))), 2'($urandom)};
            r_len = int'($urandom_range(0, 5));
            r_wl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(r_len))) : r_len;
            if ($urandom_range(0, 1) != 0)
                do_write(4'($urandom), r_addr, 8'(r_len), r_wl, $urandom, 4'($urandom), 1);
            else
                do_read(4'($urandom), r_addr, 8'(r_len), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 responder that serves the CPU-side AXI master (SRAM-to-AXI bridge) from a single-port synchronous word SRAM. It accepts one transaction at a time on the AR/AW channels, translates it into SRAM beats, and returns R or B responses with the original ID. It replaces the external AXI RAM model in block-level simulation and small SoC builds.

## Interface
- `ADDR_W`, default 16: SRAM word-address width, giving a capacity of 4·2^ADDR_W bytes.
- `aclk` in 1: the single clock; all logic is rising-edge.
- `areset` in 1: synchronous, active-high reset.
- `arid[3:0]`, `araddr[31:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `arvalid` in; `arready` out.
- `rid[3:0]`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rvalid` out; `rready` in.
- `awid[3:0]`, `awaddr[31:0]`, `awlen[7:0]`, `awsize[2:0]`, `awburst[1:0]`, `awvalid` in; `awready` out.
- `wid[3:0]`, `wdata[31:0]`, `wstrb[3:0]`, `wlast`, `wvalid` in; `wready` out.
- `bid[3:0]`, `bresp[1:0]`, `bvalid` out; `bready` in.
- `ram_en` out 1: SRAM access strobe.
- `ram_wen` out 4: byte write enables. Zero means a read.
- `ram_addr` out ADDR_W: word address.
- `ram_wdata` out 32: write data.
- `ram_rdata` in 32: read data, valid in the cycle after a read strobe.

## Operation
- FSM states: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP.
- Address handling:
  - The word address is `addr[ADDR_W+1:2]`; upper address bits are ignored.
  - arsize/awsize and arburst/awburst are ignored. Every beat is a 32-bit INCR beat.
  - `wid` is ignored.
- Arbitration in IDLE:
  - If only one of arvalid/awvalid is high, that channel is granted.
  - If both are high, the channel not granted last time wins. The last-grant bit resets to "write", so the first tie goes to read.
  - `arready`/`awready` are combinational: high only in IDLE, for the granted channel.
- On AR handshake:
  - Latch id, word address and len; clear the beat counter; go to RD_REQ.
- Read sequence:
  - RD_REQ: drive ram_en=1, ram_wen=0; go to RD_CAP.
  - RD_CAP: register ram_rdata into `rdata`; go to RD_RESP.
  - RD_RESP: rvalid=1, rid=latched id, rresp=OKAY (2'b00), rlast=(count==len).
  - On rvalid&&rready: if this is the last beat, go to IDLE; otherwise increment the address and count and go to RD_REQ.
  - rdata/rlast/rid stay stable while rready is low.
- On AW handshake:
  - Latch id, address and len; clear the beat counter and error flag; go to WR_DATA.
- WR_DATA:
  - wready=1.
  - On wvalid: ram_en=1, ram_wen=wstrb, ram_wdata=wdata, same cycle.
  - Set the error flag if wlast≠(count==len).
  - If count==len, go to WR_RESP; otherwise increment the address and count.
- WR_RESP:
  - bvalid=1, bid=latched id, bresp = error ? SLVERR (2'b10) : OKAY.
  - On bready, go to IDLE.
- Address increment wraps modulo 2^ADDR_W. The counter is 8 bits, so the maximum burst is 256 beats.

## Timing
- Reset values: FSM=IDLE; arready, awready, rvalid, bvalid, wready, ram_en = 0; ram_wen=0; rdata, rid, bid, rresp, bresp = 0; rlast=0; last-grant=write.
- Reset asserted mid-transaction: the state is dropped with no response.
  - All outputs take their reset values in the cycle after the reset edge.
  - Any in-flight SRAM write strobed before reset stands.
- Read latency: AR handshake at cycle T gives rvalid first high at T+3. Each further beat takes 3 cycles plus rready stall.
- Write: AW handshake at T gives wready from T+1. Each W beat is accepted in 1 cycle. bvalid comes the cycle after the final W beat.
- Reads and writes never overlap. arvalid/awvalid arriving during a transaction wait for IDLE.
- IDLE lasts at least one cycle between transactions.

## Configuration
- `AXI_SLV_BURST_EN` defined: full burst support as described above.
- `AXI_SLV_BURST_EN` undefined: counter logic is removed.
  - arlen/awlen==0 behave as above.
  - Read with arlen≠0: exactly one beat is returned with rlast=1 and rresp=SLVERR, and the SRAM is not read. This violates AXI; the master must not issue it.
  - Write with awlen≠0: W beats are accepted until wlast with no SRAM writes, then bresp=SLVERR.

## Test plan
- Single read, araddr=0x0000_0010, arid=3, with SRAM word 4 = 0xDEADBEEF → rvalid at T+3 with rdata=0xDEADBEEF, rid=3, rlast=1, rresp=0.
- Single write, awaddr=0x8, wdata=0x11223344, wstrb=4'b0101 → ram_addr=2, ram_wen=4'b0101. Then bvalid with bid matching awid and bresp=0; a read-back returns the merged bytes.
- 4-beat burst write then 4-beat read at 0x100, with rready toggling every cycle → data is returned in order, stable while stalled, rlast on beat 3 only.
- Write burst with awlen=1 and wlast high on beat 0 → both beats are still written, and bresp=2'b10.
- arvalid and awvalid both held high from reset → grant order is read, write, read, write.
- Reset asserted during RD_RESP → rvalid=0 the next cycle, and a fresh read then completes normally.
